uart_tx_cfg: RTL
================

Name: uart_tx_cfg

Overview:
- Next-generation UART transmitter with runtime frame format (5-8 data bits, none/even/odd parity, 1 or 2 stop bits) and runtime baud divisor.
- Includes a parametrised TX byte FIFO, so the producer can queue bytes and frames go out back-to-back without idle gaps.
- Sits between the on-chip byte producer (status/key dump logic) and the board UART pin.

Parameters:
- FIFO_DEPTH, 16, bytes of TX buffering; power of two, minimum 2.
- DIV_W, 16, width of the baud divisor input.

Ports:
- i_Clock  in  1  system clock.
- i_Rst_L  in  1  asynchronous active-low reset.
- i_Clks_Per_Bit  in  DIV_W  clocks per UART bit; values below 4 are treated as 4.
- i_Data_Bits  in  2  data bits per frame: 0=5, 1=6, 2=7, 3=8.
- i_Parity  in  2  parity mode: 0=none, 1=even, 2=odd, 3=none.
- i_Two_Stop  in  1  1 = two stop bits, 0 = one stop bit.
- i_Tx_DV  in  1  one-cycle write strobe for i_Tx_Byte.
- i_Tx_Byte  in  8  byte to queue; bits above the data length are ignored.
- o_Tx_Ready  out  1  FIFO not full.
- o_Tx_Overflow  out  1  one-cycle pulse when a write is dropped.
- o_Tx_Active  out  1  high while a frame is on the line.
- o_Tx_Serial  out  1  serial line, registered, idle high.
- o_Tx_Done  out  1  one-cycle pulse at the end of each frame.
- o_Fifo_Count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values (asynchronous, i_Rst_L low):
  - o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Overflow=0, o_Fifo_Count=0, o_Tx_Ready=1.
  - State returns to IDLE and all counters clear.
- Reset mid-frame: the line goes high immediately and the FIFO contents are discarded. No Done pulse.
- FIFO write rules:
  - i_Tx_DV while not full: byte is accepted.
  - i_Tx_DV while full: byte is dropped and o_Tx_Overflow pulses the next cycle.
  - i_Tx_DV while full, in the same cycle the FSM pops: the write is accepted and the count is unchanged.
- Config latching: divisor, data bits, parity and stop-bit settings are latched at frame start, on the pop. Changing inputs mid-frame has no effect on the current frame.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: line high. If the FIFO is non-empty, pop, latch config and the byte, and go to START.
  - START: drive 0 for the latched divisor D clocks, then go to DATA.
  - DATA: send LSB first, D clocks per bit, for N bits. Then go to PARITY if parity is enabled, else STOP.
  - PARITY: drive the XOR of the N sent bits for even parity, or its inverse for odd; D clocks.
  - STOP: drive 1 for D clocks, or 2·D if two stop bits are selected. On completion, o_Tx_Done pulses for 1 cycle.
    - If the FIFO is non-empty, pop in that same cycle and go directly to START, so there is no idle bit between frames.
    - Otherwise go to IDLE.
- Latency: write into an empty idle FIFO at edge k; the start bit appears on o_Tx_Serial after edge k+2.
- Frame length: D·(1+N+P+S) clocks, where P is 0 or 1 and S is 1 or 2.
- o_Tx_Active:
  - Rises with the start bit and stays high across back-to-back frames.
  - Falls in the cycle the line returns to IDLE.
- Bit timing: the bit counter runs 0..D-1 and must not overflow for D = 2^DIV_W-1.
- o_Fifo_Count is exact at all times. A simultaneous write and pop leaves it unchanged.

Decomposition:
- Package uart_pkg holds:
  - state encoding constants;
  - parity mode constants (PAR_NONE, PAR_EVEN, PAR_ODD);
  - data-length encoding;
  - minimum divisor constant 4.
- Sub-module uart_fifo_sync: parametrised synchronous FIFO with width 8, depth FIFO_DEPTH, async active-low reset, full/empty/count outputs, and first-word-fall-through read.
- The top level contains only the FSM, the baud counter and the shift register.

Test Plan:
- 8N1, D=4, write 0xA5 → line reads 0,1,0,1,0,0,1,0,1,1, 4 clocks each, 40 clocks total. Done pulses once, Active is high for 40 clocks.
- 7E2, D=5, write 0x53 → data bits 1,1,0,0,1,0,1, parity 0, two stop bits (10 clocks high); byte bit 7 is ignored.
- 5O1, D=4, three writes 0x1F, 0x00, 0x15 back-to-back → three frames with zero idle gap. Parity bits are 0, 1, 0. Three Done pulses, Active continuously high.
- FIFO_DEPTH=4, D=100, write 6 bytes in 6 consecutive cycles:
  - 5 bytes are accepted (the first is popped immediately), the 6th is dropped;
  - o_Tx_Overflow pulses once;
  - the count peaks at 4.
- Reset asserted mid-DATA of frame 1 with 3 bytes queued → o_Tx_Serial=1 asynchronously, count=0, no Done. After release the line stays idle.
- i_Clks_Per_Bit=1 → behaves as D=4. Changing i_Parity during a frame → the current frame keeps its latched mode and the next frame uses the new one.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared encodings for the configurable UART transmitter: FSM states, parity
// modes, data-length codes and the divisor floor.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  localparam logic [1:0] DATA_5 = 2'd0;
  localparam logic [1:0] DATA_6 = 2'd1;
  localparam logic [1:0] DATA_7 = 2'd2;
  localparam logic [1:0] DATA_8 = 2'd3;

  localparam int unsigned MIN_CLKS_PER_BIT = 4;

  function automatic logic [3:0] data_len(logic [1:0] code);
    return 4'd5 + {2'b00, code};
  endfunction

  function automatic logic [7:0] data_mask(logic [1:0] code);
    logic [7:0] m;
    m = 8'hFF;
    unique case (code)
      DATA_5: m = 8'h1F;
      DATA_6: m = 8'h3F;
      DATA_7: m = 8'h7F;
      DATA_8: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Producer-side write port of uart_tx_cfg: byte strobe plus FIFO status.
interface uart_tx_cfg_if #(
  parameter int unsigned FIFO_DEPTH = 16
) ();
  logic                          i_Tx_DV;
  logic [7:0]                    i_Tx_Byte;
  logic                          o_Tx_Ready;
  logic                          o_Tx_Overflow;
  logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count;

  modport master (
    output i_Tx_DV, i_Tx_Byte,
    input  o_Tx_Ready, o_Tx_Overflow, o_Fifo_Count
  );

  modport slave (
    input  i_Tx_DV, i_Tx_Byte,
    output o_Tx_Ready, o_Tx_Overflow, o_Fifo_Count
  );
endinterface

// File: rtl/uart_fifo_sync.sv
// Synchronous first-word-fall-through FIFO; a write while full is accepted only
// when a read frees a slot in the same cycle.
module uart_fifo_sync #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       i_Clock,
  input  logic                       i_Rst_L,
  input  logic                       i_Wr_En,
  input  logic [WIDTH-1:0]           i_Wr_Data,
  input  logic                       i_Rd_En,
  output logic [WIDTH-1:0]           o_Rd_Data,
  output logic                       o_Full,
  output logic                       o_Empty,
  output logic                       o_Drop,
  output logic [$clog2(DEPTH):0]     o_Count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign o_Full    = (count_q == CW'(DEPTH));
  assign o_Empty   = (count_q == '0);
  assign do_pop    = i_Rd_En && !o_Empty;
  assign do_push   = i_Wr_En && (!o_Full || do_pop);
  assign o_Drop    = i_Wr_En && !do_push;
  assign o_Rd_Data = mem_q[rd_ptr_q];
  assign o_Count   = count_q;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (do_push) mem_q[wr_ptr_q] <= i_Wr_Data;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with runtime frame format and baud divisor, fed from a byte
// FIFO; frame settings are captured on each pop so mid-frame changes are inert.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic             i_Clock,
  input  logic             i_Rst_L,
  input  logic [DIV_W-1:0] i_Clks_Per_Bit,
  input  logic [1:0]       i_Data_Bits,
  input  logic [1:0]       i_Parity,
  input  logic             i_Two_Stop,
  uart_tx_cfg_if.slave     tx_if,
  output logic             o_Tx_Active,
  output logic             o_Tx_Serial,
  output logic             o_Tx_Done
);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic            fifo_empty, fifo_full, fifo_drop, pop;
  logic [7:0]      fifo_data, byte_masked;
  logic [CntW-1:0] fifo_count;

  tx_state_e        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, div_eff;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [3:0]       nbits_q, nbits_d;
  logic             par_en_q, par_en_d, par_bit_q, par_bit_d, two_stop_q, two_stop_d;
  logic             par_en_new, par_bit_new;
  logic             serial_q, line_d, active_q, done_q, done_d, ovf_q;
  logic             bit_end, last_data, frame_start;

  uart_fifo_sync #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .i_Clock   (i_Clock),
    .i_Rst_L   (i_Rst_L),
    .i_Wr_En   (tx_if.i_Tx_DV),
    .i_Wr_Data (tx_if.i_Tx_Byte),
    .i_Rd_En   (pop),
    .o_Rd_Data (fifo_data),
    .o_Full    (fifo_full),
    .o_Empty   (fifo_empty),
    .o_Drop    (fifo_drop),
    .o_Count   (fifo_count)
  );

  // Settings sampled from the live inputs; only used on the pop cycle.
  always_comb begin
    div_eff     = (i_Clks_Per_Bit < DIV_W'(MIN_CLKS_PER_BIT)) ?
                  DIV_W'(MIN_CLKS_PER_BIT) : i_Clks_Per_Bit;
    byte_masked = fifo_data & data_mask(i_Data_Bits);
    par_en_new  = 1'b0;
    par_bit_new = 1'b0;
    unique case (i_Parity)
      PAR_NONE: par_en_new = 1'b0;
      PAR_EVEN: begin par_en_new = 1'b1; par_bit_new = ^byte_masked;  end
      PAR_ODD:  begin par_en_new = 1'b1; par_bit_new = ~^byte_masked; end
      default:  par_en_new = 1'b0;
    endcase
  end

  assign bit_end   = (cnt_q == div_q - DIV_W'(1));
  assign last_data = (bit_q == 3'(nbits_q - 4'd1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    div_d       = div_q;
    nbits_d     = nbits_q;
    par_en_d    = par_en_q;
    par_bit_d   = par_bit_q;
    two_stop_d  = two_stop_q;
    done_d      = 1'b0;
    frame_start = 1'b0;
    line_d      = 1'b1;

    if (state_q != StIdle) cnt_d = bit_end ? '0 : cnt_q + DIV_W'(1);

    unique case (state_q)
      StIdle: frame_start = !fifo_empty;
      StStart: begin
        line_d = 1'b0;
        if (bit_end) begin
          state_d = StData;
          bit_d   = '0;
        end
      end
      StData: begin
        line_d = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (last_data) begin
            bit_d   = '0;
            state_d = par_en_q ? StParity : StStop;
          end
        end
      end
      StParity: begin
        line_d = par_bit_q;
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (bit_end) begin
          if (two_stop_q && (bit_q == 3'd0)) begin
            bit_d = 3'd1;
          end else begin
            done_d = 1'b1;
            // Chain straight into the next start bit when more bytes wait.
            if (!fifo_empty) frame_start = 1'b1;
            else             state_d     = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (frame_start) begin
      state_d    = StStart;
      cnt_d      = '0;
      bit_d      = '0;
      shift_d    = byte_masked;
      div_d      = div_eff;
      nbits_d    = data_len(i_Data_Bits);
      par_en_d   = par_en_new;
      par_bit_d  = par_bit_new;
      two_stop_d = i_Two_Stop;
    end
  end

  assign pop = frame_start;

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      div_q      <= DIV_W'(MIN_CLKS_PER_BIT);
      nbits_q    <= 4'd8;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      serial_q   <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      div_q      <= div_d;
      nbits_q    <= nbits_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      serial_q   <= line_d;
      active_q   <= (state_q != StIdle);
      done_q     <= done_d;
      ovf_q      <= fifo_drop;
    end
  end

  assign o_Tx_Serial         = serial_q;
  assign o_Tx_Active         = active_q;
  assign o_Tx_Done           = done_q;
  assign tx_if.o_Tx_Ready    = !fifo_full;
  assign tx_if.o_Tx_Overflow = ovf_q;
  assign tx_if.o_Fifo_Count  = fifo_count;

endmodule
